// File: rtl/stream_combiner_pkg.sv
// Shared definitions for the stream combiner.
// Field widths travel as one packed list of MAX_INPUTS 32-bit entries, entry k
// at bits [32*k +: 32]. The offset and width-sum helpers are also used by the
// splitter, so both ends agree on where each field sits in the word.
package stream_combiner_pkg;

  localparam int MAX_INPUTS = 8;
  localparam int WIDTH_BITS = 32;

  typedef logic [MAX_INPUTS*WIDTH_BITS-1:0] width_list_t;

  // Width of field k.
  function automatic int field_width(input int k, input width_list_t widths);
    return int'(widths[k*WIDTH_BITS +: WIDTH_BITS]);
  endfunction

  // Bit position of field k: the sum of the widths of all fields below it.
  function automatic int field_offset(input int k, input width_list_t widths);
    int sum;
    sum = 0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (i < k) sum += int'(widths[i*WIDTH_BITS +: WIDTH_BITS]);
    end
    return sum;
  endfunction

  // Total width of the first n fields.
  function automatic int width_sum(input int n, input width_list_t widths);
    return field_offset(n, widths);
  endfunction

endpackage

// File: rtl/stream_combiner_skid.sv
// Two-entry skid FIFO used on each combiner input.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_valid       - upstream beat valid; accepted when o_ready is also high
//   i_data        - upstream beat data
//   i_pop         - remove the head entry (ignored while empty)
//   o_data        - head entry
//   o_ready       - registered "fewer than two entries"
//   o_not_empty   - registered "at least one entry"
// Both status flags are computed from the next occupancy, so they are
// registered yet still correct in the cycle after every push or pop.
module stream_combiner_skid
  import stream_combiner_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ready,
  output logic             o_not_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             r_ready;
  logic             r_not_empty;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_next;

  assign w_push = i_valid & r_ready;
  assign w_pop  = i_pop & r_not_empty;

  // Push and pop together leave the occupancy, and so the flags, unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
      r_ready     <= 1'b1;
      r_not_empty <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count     <= w_count_next;
      r_ready     <= (w_count_next != 2'd2);
      r_not_empty <= (w_count_next != 2'd0);
    end
  end

  // Storage needs no reset: the occupancy count decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data      = r_mem[r_rptr];
  assign o_ready     = r_ready;
  assign o_not_empty = r_not_empty;

endmodule

// File: rtl/stream_combiner.sv
// Joins up to eight AXI-Stream field streams into one concatenated word.
// Field k comes from input k, packed from the LSB up (IN0 in the low bits).
// Ports:
//   CLK, RST                   - clock, synchronous active-high reset
//   INk_TDATA/TVALID/TREADY    - field stream k (k = 0..7, first NUM_INPUTS used)
//   IN0_TLAST                  - frame marker, taken from input 0 only
//   OUT0_TDATA/TVALID/TREADY   - joined word stream
//   OUT0_TLAST                 - IN0_TLAST carried with the joined word
//   BEAT_COUNT                 - output handshakes since reset, wraps at 2^32
// Handshake: a beat moves on any interface on a rising edge where TVALID and
// TREADY are both high; a source holds TVALID and its data until that edge.
// Input TREADY is registered and depends only on FIFO occupancy.
module stream_combiner
  import stream_combiner_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IN0_WIDTH  = 1,
  parameter int IN1_WIDTH  = 1,
  parameter int IN2_WIDTH  = 1,
  parameter int IN3_WIDTH  = 1,
  parameter int IN4_WIDTH  = 1,
  parameter int IN5_WIDTH  = 1,
  parameter int IN6_WIDTH  = 1,
  parameter int IN7_WIDTH  = 1,
  parameter int OUT0_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [IN0_WIDTH-1:0]  IN0_TDATA,
  input  logic                  IN0_TVALID,
  output logic                  IN0_TREADY,
  input  logic                  IN0_TLAST,
  input  logic [IN1_WIDTH-1:0]  IN1_TDATA,
  input  logic                  IN1_TVALID,
  output logic                  IN1_TREADY,
  input  logic [IN2_WIDTH-1:0]  IN2_TDATA,
  input  logic                  IN2_TVALID,
  output logic                  IN2_TREADY,
  input  logic [IN3_WIDTH-1:0]  IN3_TDATA,
  input  logic                  IN3_TVALID,
  output logic                  IN3_TREADY,
  input  logic [IN4_WIDTH-1:0]  IN4_TDATA,
  input  logic                  IN4_TVALID,
  output logic                  IN4_TREADY,
  input  logic [IN5_WIDTH-1:0]  IN5_TDATA,
  input  logic                  IN5_TVALID,
  output logic                  IN5_TREADY,
  input  logic [IN6_WIDTH-1:0]  IN6_TDATA,
  input  logic                  IN6_TVALID,
  output logic                  IN6_TREADY,
  input  logic [IN7_WIDTH-1:0]  IN7_TDATA,
  input  logic                  IN7_TVALID,
  output logic                  IN7_TREADY,
  output logic [OUT0_WIDTH-1:0] OUT0_TDATA,
  output logic                  OUT0_TVALID,
  input  logic                  OUT0_TREADY,
  output logic                  OUT0_TLAST,
  output logic [31:0]           BEAT_COUNT
);

  localparam width_list_t WIDTHS = {32'(IN7_WIDTH), 32'(IN6_WIDTH), 32'(IN5_WIDTH),
                                    32'(IN4_WIDTH), 32'(IN3_WIDTH), 32'(IN2_WIDTH),
                                    32'(IN1_WIDTH), 32'(IN0_WIDTH)};
  localparam int ALL_WIDTH = width_sum(MAX_INPUTS, WIDTHS);

  if (NUM_INPUTS < 1 || NUM_INPUTS > MAX_INPUTS) begin : g_bad_count
    $error("stream_combiner: NUM_INPUTS must be 1..8");
  end
  if (OUT0_WIDTH != width_sum(NUM_INPUTS, WIDTHS)) begin : g_bad_width
    $error("stream_combiner: OUT0_WIDTH must equal the sum of the active input widths");
  end

  // All eight inputs laid out exactly as the output word; the active fields
  // therefore occupy bits [OUT0_WIDTH-1:0] at their final positions.
  logic [ALL_WIDTH-1:0]  w_in_data;
  logic [MAX_INPUTS-1:0] w_in_valid;
  logic [MAX_INPUTS-1:0] w_in_ready;
  logic [OUT0_WIDTH-1:0] w_head_data;
  logic                  w_head_last;
  logic [NUM_INPUTS-1:0] w_not_empty;
  logic                  w_join;
  logic                  w_unused;

  logic [OUT0_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [31:0]           r_beat_count;

  assign w_in_data  = {IN7_TDATA, IN6_TDATA, IN5_TDATA, IN4_TDATA,
                       IN3_TDATA, IN2_TDATA, IN1_TDATA, IN0_TDATA};
  assign w_in_valid = {IN7_TVALID, IN6_TVALID, IN5_TVALID, IN4_TVALID,
                       IN3_TVALID, IN2_TVALID, IN1_TVALID, IN0_TVALID};
  // Inactive inputs are deliberately ignored.
  assign w_unused   = ^{w_in_data, w_in_valid};

  for (genvar k = 0; k < MAX_INPUTS; k++) begin : g_in
    localparam int OFF = field_offset(k, WIDTHS);
    localparam int W   = field_width(k, WIDTHS);
    if (k == 0) begin : g_first
      // Input 0 carries TLAST as the extra top bit of its FIFO entry.
      logic [W:0] w_head;
      stream_combiner_skid #(.WIDTH(W + 1)) u_skid (
        .clk         (CLK),
        .rst         (RST),
        .i_valid     (w_in_valid[0]),
        .i_data      ({IN0_TLAST, w_in_data[OFF +: W]}),
        .i_pop       (w_join),
        .o_data      (w_head),
        .o_ready     (w_in_ready[0]),
        .o_not_empty (w_not_empty[0])
      );
      assign w_head_data[OFF +: W] = w_head[W-1:0];
      assign w_head_last           = w_head[W];
    end else if (k < NUM_INPUTS) begin : g_active
      stream_combiner_skid #(.WIDTH(W)) u_skid (
        .clk         (CLK),
        .rst         (RST),
        .i_valid     (w_in_valid[k]),
        .i_data      (w_in_data[OFF +: W]),
        .i_pop       (w_join),
        .o_data      (w_head_data[OFF +: W]),
        .o_ready     (w_in_ready[k]),
        .o_not_empty (w_not_empty[k])
      );
    end else begin : g_idle
      assign w_in_ready[k] = 1'b0;
    end
  end

  // Join when every active FIFO has a head and the output slot frees up
  // this edge; the pop of all FIFOs and the output load happen together.
  assign w_join = (&w_not_empty) & (~r_out_valid | OUT0_TREADY);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_beat_count <= '0;
    end else begin
      if (w_join) begin
        r_out_data  <= w_head_data;
        r_out_last  <= w_head_last;
        r_out_valid <= 1'b1;
      end else if (OUT0_TREADY) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid & OUT0_TREADY) r_beat_count <= r_beat_count + 32'd1;
    end
  end

  assign OUT0_TDATA  = r_out_data;
  assign OUT0_TVALID = r_out_valid;
  assign OUT0_TLAST  = r_out_last;
  assign BEAT_COUNT  = r_beat_count;

  assign IN0_TREADY = w_in_ready[0];
  assign IN1_TREADY = w_in_ready[1];
  assign IN2_TREADY = w_in_ready[2];
  assign IN3_TREADY = w_in_ready[3];
  assign IN4_TREADY = w_in_ready[4];
  assign IN5_TREADY = w_in_ready[5];
  assign IN6_TREADY = w_in_ready[6];
  assign IN7_TREADY = w_in_ready[7];

endmodule
